// File: rtl/tcm_trig_link_rx.sv
// TCM-side receiver for the PM trigger frame: deserialises tt/ta, checks integrity, tracks lock.
// Optional TCM_TRIG_RX_STATS_EN adds trig_cnt/vtx_cnt event counters.
module tcm_trig_link_rx #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int VTX_WIN    = 32
) (
   input  logic              clk320,
   input  logic              rst_n,
   input  logic [2:0]        mt_cou,
   input  logic              tcm_req,
   input  logic [1:0]        tt,
   input  logic [1:0]        ta,
   output logic              trig_valid,
   output logic [3:0]        n_ch,
   output logic signed [8:0] t_avg,
   output logic [12:0]       a_sum,
   output logic              trig_or,
   output logic              trig_vtx,
   output logic              link_ok,
   output logic [15:0]       err_cnt
`ifdef TCM_TRIG_RX_STATS_EN
   ,
   output logic [31:0]       trig_cnt,
   output logic [31:0]       vtx_cnt
`else
`endif
);
   // state       | meaning
   // ST_UNLOCKED | no lock, waiting for a first good frame
   // ST_LOCKING  | counting consecutive good frames toward LOCK_CNT
   // ST_LOCKED   | link up, triggers forwarded, bad frames counted toward UNLOCK_CNT
   typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKING, ST_LOCKED} state_t;

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_CNT + 1);
   localparam logic [GW-1:0] LOCK_TH   = GW'(LOCK_CNT);
   localparam logic [BW-1:0] UNLOCK_TH = BW'(UNLOCK_CNT);
   localparam logic [9:0]    VTX_TH    = 10'(VTX_WIN);

   logic [1:0]        r_rst_sync;
   logic              w_rst_n;
   logic [13:0]       r_tt_sh, r_ta_sh;
   logic [2:0]        r_prev_ph;
   logic              r_ph_err;
   state_t            r_state;
   logic [GW-1:0]     r_good_cnt;
   logic [BW-1:0]     r_bad_cnt;
   logic [15:0]       r_err_cnt;
   logic              r_link_ok, r_trig_valid, r_trig_or, r_trig_vtx;
   logic [3:0]        r_n_ch;
   logic signed [8:0] r_t_avg;
   logic [12:0]       r_a_sum;

   logic [15:0]       w_tt_word, w_ta_word;
   logic              w_ph_err_now, w_eval, w_good, w_fire, w_vtx;
   logic signed [8:0] w_t;
   logic [9:0]        w_t_abs;

   // Async assert, synchronous release of the internal reset.
   always_ff @(posedge clk320 or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_tt_word    = {r_tt_sh, tt};
   assign w_ta_word    = {r_ta_sh, ta};
   assign w_ph_err_now = (mt_cou != (r_prev_ph + 3'd1));
   assign w_eval       = (mt_cou == 3'd7);
   assign w_t          = w_tt_word[9:1];
   assign w_t_abs      = w_t[8] ? (10'd0 - {1'b1, w_t}) : {1'b0, w_t};
   assign w_good = (w_tt_word[15:14] == 2'b10) && (w_ta_word[15:14] == 2'b01) &&
                   (^w_tt_word) && (^w_ta_word) && (w_tt_word[13:10] <= 4'd12) &&
                   !(r_ph_err || w_ph_err_now);
   assign w_fire = w_eval && w_good && tcm_req && (r_state == ST_LOCKED);
   assign w_vtx  = (w_tt_word[13:10] != 4'd0) && (w_t_abs <= VTX_TH);

   // A phase error taints the rest of the frame; phase 0 starts a clean frame.
   always_ff @(posedge clk320 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_tt_sh   <= '0;
         r_ta_sh   <= '0;
         r_prev_ph <= 3'd7;
         r_ph_err  <= 1'b0;
      end else begin
         r_tt_sh   <= {r_tt_sh[11:0], tt};
         r_ta_sh   <= {r_ta_sh[11:0], ta};
         r_prev_ph <= mt_cou;
         r_ph_err  <= (mt_cou == 3'd0) ? w_ph_err_now : (r_ph_err || w_ph_err_now);
      end
   end

   always_ff @(posedge clk320 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= ST_UNLOCKED;
         r_good_cnt <= '0;
         r_bad_cnt  <= '0;
         r_err_cnt  <= '0;
         r_link_ok  <= 1'b0;
      end else if (w_eval) begin
         case (r_state)
            ST_UNLOCKED: begin
               if (w_good) begin
                  r_state    <= ST_LOCKING;
                  r_good_cnt <= GW'(1);
               end
            end
            ST_LOCKING: begin
               if (w_good) begin
                  if (r_good_cnt + GW'(1) == LOCK_TH) begin
                     r_state    <= ST_LOCKED;
                     r_good_cnt <= '0;
                     r_bad_cnt  <= '0;
                     r_link_ok  <= 1'b1;
                  end else begin
                     r_good_cnt <= r_good_cnt + GW'(1);
                  end
               end else begin
                  r_state    <= ST_UNLOCKED;
                  r_good_cnt <= '0;
                  if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
               end
            end
            ST_LOCKED: begin
               if (w_good) begin
                  r_bad_cnt <= '0;
               end else begin
                  if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                  if (r_bad_cnt + BW'(1) == UNLOCK_TH) begin
                     r_state   <= ST_UNLOCKED;
                     r_bad_cnt <= '0;
                     r_link_ok <= 1'b0;
                  end else begin
                     r_bad_cnt <= r_bad_cnt + BW'(1);
                  end
               end
            end
            default: begin
               r_state   <= ST_UNLOCKED;
               r_link_ok <= 1'b0;
            end
         endcase
      end
   end

   // Decoded fields hold their last triggered value between pulses.
   always_ff @(posedge clk320 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_trig_valid <= 1'b0;
         r_n_ch       <= '0;
         r_t_avg      <= '0;
         r_a_sum      <= '0;
         r_trig_or    <= 1'b0;
         r_trig_vtx   <= 1'b0;
      end else begin
         r_trig_valid <= w_fire;
         if (w_fire) begin
            r_n_ch     <= w_tt_word[13:10];
            r_t_avg    <= w_t;
            r_a_sum    <= w_ta_word[13:1];
            r_trig_or  <= (w_tt_word[13:10] != 4'd0);
            r_trig_vtx <= w_vtx;
         end
      end
   end

`ifdef TCM_TRIG_RX_STATS_EN
   logic [31:0] r_trig_cnt, r_vtx_cnt;
   always_ff @(posedge clk320 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_trig_cnt <= '0;
         r_vtx_cnt  <= '0;
      end else if (w_fire) begin
         r_trig_cnt <= r_trig_cnt + 32'd1;
         if (w_vtx) r_vtx_cnt <= r_vtx_cnt + 32'd1;
      end
   end
   assign trig_cnt = r_trig_cnt;
   assign vtx_cnt  = r_vtx_cnt;
`else
`endif

   assign trig_valid = r_trig_valid;
   assign n_ch       = r_n_ch;
   assign t_avg      = r_t_avg;
   assign a_sum      = r_a_sum;
   assign trig_or    = r_trig_or;
   assign trig_vtx   = r_trig_vtx;
   assign link_ok    = r_link_ok;
   assign err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_tcm_trig_link_rx.sv
// Scoreboard bench for tcm_trig_link_rx: frame-level reference model, monitor pops expected triggers.
module tb_tcm_trig_link_rx;
   logic              clk320 = 1'b0;
   logic              rst_n  = 1'b1;
   logic [2:0]        mt_cou = 3'd0;
   logic              tcm_req = 1'b0;
   logic [1:0]        tt = 2'b00, ta = 2'b00;
   logic              trig_valid, trig_or, trig_vtx, link_ok;
   logic [3:0]        n_ch;
   logic signed [8:0] t_avg;
   logic [12:0]       a_sum;
   logic [15:0]       err_cnt;
`ifdef TCM_TRIG_RX_STATS_EN
   logic [31:0]       trig_cnt, vtx_cnt;
`endif

   tcm_trig_link_rx dut (
      .clk320(clk320), .rst_n(rst_n), .mt_cou(mt_cou), .tcm_req(tcm_req),
      .tt(tt), .ta(ta), .trig_valid(trig_valid), .n_ch(n_ch), .t_avg(t_avg),
      .a_sum(a_sum), .trig_or(trig_or), .trig_vtx(trig_vtx), .link_ok(link_ok),
      .err_cnt(err_cnt)
`ifdef TCM_TRIG_RX_STATS_EN
      , .trig_cnt(trig_cnt), .vtx_cnt(vtx_cnt)
`endif
   );

   always #2 clk320 = ~clk320;

   typedef struct {int n; int t; int a; bit or_f; bit vtx;} exp_t;
   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0, n_err = 0;
   int   m_state = 0, m_good = 0, m_bad = 0, m_err = 0, m_trig = 0, m_vtx = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] make_tt(input int n, input int t);
      logic [15:0] w;
      w = {2'b10, n[3:0], t[8:0], 1'b0};
      w[0] = ~^w[15:1];
      return w;
   endfunction

   function automatic logic [15:0] make_ta(input int a);
      logic [15:0] w;
      w = {2'b01, a[12:0], 1'b0};
      w[0] = ~^w[15:1];
      return w;
   endfunction

   function automatic void reset_model();
      m_state = 0; m_good = 0; m_bad = 0; m_err = 0; m_trig = 0; m_vtx = 0;
      sb_q.delete();
   endfunction

   // Frame-level reference: goodness comes from what the stimulus intended to corrupt.
   function automatic bit model_frame(input bit req, input int n, input int t, input int a,
                                      input int kind, input bit jump);
      bit   good, fire;
      exp_t e;
      int   at;
      good = (kind == 0) && (n <= 12) && !jump;
      fire = good && req && (m_state == 2);
      if (fire) begin
         at = (t < 0) ? -t : t;
         e.n = n; e.t = t; e.a = a; e.or_f = (n != 0); e.vtx = (n != 0) && (at <= 32);
         sb_q.push_back(e);
         m_trig++;
         if (e.vtx) m_vtx++;
      end
      if (m_state == 0) begin
         if (good) begin m_state = 1; m_good = 1; end
      end else if (m_state == 1) begin
         if (good) begin
            m_good++;
            if (m_good == 4) begin m_state = 2; m_good = 0; m_bad = 0; end
         end else begin
            m_state = 0; m_good = 0;
            if (m_err < 65535) m_err++;
         end
      end else begin
         if (good) m_bad = 0;
         else begin
            m_bad++;
            if (m_err < 65535) m_err++;
            if (m_bad == 3) begin m_state = 0; m_bad = 0; end
         end
      end
      return fire;
   endfunction

   // kind: 0 ok, 1 tt parity, 2 ta parity, 3 tt header, 4 ta header, 5 all-zero junk
   task automatic send_frame(input bit req, input int n, input int t, input int a,
                             input int kind, input bit jump);
      logic [15:0] tw, aw;
      bit fire;
      tw = make_tt(n, t);
      aw = make_ta(a);
      case (kind)
         1: tw[0] = ~tw[0];
         2: aw[0] = ~aw[0];
         3: tw[15:14] = 2'b11;
         4: aw[15:14] = 2'b00;
         5: begin tw = '0; aw = '0; end
         default: ;
      endcase
      for (int p = 0; p < 8; p++) begin
         if (!(jump && p == 4)) begin
            @(negedge clk320);
            mt_cou  = 3'(p);
            tt      = tw[15-2*p -: 2];
            ta      = aw[15-2*p -: 2];
            tcm_req = req;
         end
      end
      fire = model_frame(req, n, t, a, kind, jump);
      @(posedge clk320); #1;
      chk("trig_valid", trig_valid, fire);
      chk("link_ok", link_ok, (m_state == 2));
      chk("err_cnt", err_cnt, m_err);
   endtask

   task automatic reset_tail(input int start);
      for (int p = start; p < 8; p++) begin
         @(negedge clk320);
         mt_cou = 3'(p); tt = 2'b00; ta = 2'b00; tcm_req = 1'b0;
      end
      rst_n = 1'b1;
      repeat (2) send_frame(1'b0, 0, 0, 0, 5, 1'b0);
   endtask

   task automatic lock_up();
      repeat (4) send_frame(1'b0, 0, 0, 0, 0, 1'b0);
   endtask

   always @(negedge clk320) begin
      if (trig_valid) begin
         if (sb_q.size() == 0) chk("unexpected_trig", 1, 0);
         else begin
            mon_e = sb_q.pop_front();
            chk("n_ch", n_ch, mon_e.n);
            chk("t_avg", $signed(t_avg), mon_e.t);
            chk("a_sum", a_sum, mon_e.a);
            chk("trig_or", trig_or, mon_e.or_f);
            chk("trig_vtx", trig_vtx, mon_e.vtx);
         end
      end
   end

   initial begin
      logic [15:0] tw, aw;
      int n, t, a, kind;
      bit req, jump;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_link_ok", link_ok, 0);
      chk("rst_trig_valid", trig_valid, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_n_ch", n_ch, 0);
      reset_model();
      reset_tail(0);

      lock_up();
      send_frame(1'b1, 5, -20, 1000, 0, 1'b0);
      send_frame(1'b1, 3, 33, 4000, 0, 1'b0);
      send_frame(1'b1, 1, -256, 8191, 0, 1'b0);
      send_frame(1'b1, 12, 32, 7, 0, 1'b0);

      repeat (3) send_frame(1'b1, 5, 1, 1, 1, 1'b0);
      lock_up();
      send_frame(1'b1, 2, -32, 11, 0, 1'b0);
      send_frame(1'b1, 2, 3, 11, 2, 1'b0);
      send_frame(1'b1, 7, -33, 12, 0, 1'b0);

      send_frame(1'b1, 4, 10, 77, 0, 1'b1);
      send_frame(1'b1, 6, -5, 300, 0, 1'b0);
      send_frame(1'b1, 13, 0, 5, 0, 1'b0);
      send_frame(1'b1, 9, 100, 2048, 0, 1'b0);

      // Reset in the middle of a valid frame.
      tw = make_tt(8, 15);
      aw = make_ta(555);
      for (int p = 0; p < 4; p++) begin
         @(negedge clk320);
         mt_cou = 3'(p); tt = tw[15-2*p -: 2]; ta = aw[15-2*p -: 2]; tcm_req = 1'b1;
      end
      @(negedge clk320);
      mt_cou = 3'd4; tt = tw[7:6]; ta = aw[7:6];
      rst_n = 1'b0;
      #1;
      chk("mid_rst_trig_valid", trig_valid, 0);
      chk("mid_rst_n_ch", n_ch, 0);
      chk("mid_rst_t_avg", t_avg, 0);
      chk("mid_rst_a_sum", a_sum, 0);
      chk("mid_rst_trig_or", trig_or, 0);
      chk("mid_rst_link_ok", link_ok, 0);
      chk("mid_rst_err_cnt", err_cnt, 0);
      reset_model();
      reset_tail(5);
`ifdef TCM_TRIG_RX_STATS_EN
      chk("trig_cnt_rst", trig_cnt, 0);
      chk("vtx_cnt_rst", vtx_cnt, 0);
`endif
      lock_up();
      send_frame(1'b1, 3, -4, 50, 0, 1'b0);
      send_frame(1'b1, 10, 200, 60, 0, 1'b0);
`ifdef TCM_TRIG_RX_STATS_EN
      chk("trig_cnt_2", trig_cnt, m_trig);
      chk("vtx_cnt_2", vtx_cnt, m_vtx);
`endif

      for (int i = 0; i < 80; i++) begin
         n    = int'($urandom_range(0, 13));
         t    = int'($urandom_range(0, 511)) - 256;
         a    = int'($urandom_range(0, 8191));
         req  = ($urandom_range(0, 3) != 0);
         kind = ($urandom_range(0, 99) < 15) ? int'($urandom_range(1, 4)) : 0;
         jump = ($urandom_range(0, 99) < 5);
         send_frame(req, n, t, a, kind, jump);
      end
`ifdef TCM_TRIG_RX_STATS_EN
      chk("trig_cnt_end", trig_cnt, m_trig);
      chk("vtx_cnt_end", vtx_cnt, m_vtx);
`endif

      repeat (3) @(negedge clk320);
      #1;
      chk("sb_drain", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
